// File: rtl/wdt_pkg.sv
// Shared types and helpers for the watchdog kick controller.
package wdt_pkg;

    localparam int unsigned MS_W = 16;
    localparam int unsigned ST_W = 3;

    typedef logic [MS_W-1:0] ms_t;

    typedef enum logic [ST_W-1:0] {
        ST_DISABLED = 3'd0,
        ST_ARMING   = 3'd1,
        ST_RUN      = 3'd2,
        ST_FAULT    = 3'd3,
        ST_RECOVER  = 3'd4
    } state_e;

    // Saturating increment of a ms counter, never exceeds lim.
    function automatic ms_t sat_inc(input ms_t val, input ms_t lim);
        return (val >= lim) ? lim : ms_t'(val + ms_t'(1));
    endfunction

endpackage

// File: rtl/wdt_src_monitor.sv
// Per-source liveness tracker: heartbeat-seen flag and ms age counter.
module wdt_src_monitor
    import wdt_pkg::*;
#(
    parameter ms_t TIMEOUT_MS = 16'd40
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic seen_clr,
    input  logic hb,
    input  logic tick,
    input  logic mask,
    output logic seen,
    output logic expire
);

    localparam ms_t AGE_LAST = ms_t'(TIMEOUT_MS - ms_t'(1));

    ms_t  age_q, age_d;
    logic seen_q, seen_d;

    // Next age / seen: a heartbeat beats both the tick and a service clear.
    always_comb begin
        age_d  = age_q;
        seen_d = seen_q;
        if (clr) begin
            age_d  = '0;
            seen_d = 1'b0;
        end else begin
            if (hb) begin
                age_d = '0;
            end else if (tick) begin
                age_d = sat_inc(age_q, TIMEOUT_MS);
            end
            if (hb) begin
                seen_d = 1'b1;
            end else if (seen_clr) begin
                seen_d = 1'b0;
            end
        end
    end

    // Age and seen registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            age_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            age_q  <= age_d;
            seen_q <= seen_d;
        end
    end

    // Fires on the tick that would make the age reach the timeout.
    assign expire = mask && tick && !hb && (age_q == AGE_LAST);
    assign seen   = seen_q;

endmodule

// File: rtl/wdt_kick_ctrl.sv
// Gates WDT service on liveness of all supervised tasks; stops kicking on a stall.
module wdt_kick_ctrl
    import wdt_pkg::*;
#(
    parameter int unsigned N_SRC      = 4,
    parameter ms_t         HOLDOFF_MS = 16'd100,
    parameter ms_t         MIN_MS     = 16'd10,
    parameter ms_t         TIMEOUT_MS = 16'd40
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_1ms,
    input  logic             en,
    input  logic [N_SRC-1:0] src_mask,
    input  logic [N_SRC-1:0] hb,
    input  logic             wdt_out,
    output logic             kick,
    output logic [N_SRC-1:0] stall,
    output logic             fault,
    output logic [ST_W-1:0]  state
);

    state_e           state_q, state_d;
    ms_t              hold_cnt_q, hold_cnt_d;
    ms_t              since_q, since_d;
    logic             kick_q, kick_d;
    logic [N_SRC-1:0] stall_q, stall_d;
    logic             fault_q, fault_d;

    logic [N_SRC-1:0] seen_vec;
    logic [N_SRC-1:0] expire_vec;
    logic             kick_fire_c;
    logic             mon_clr_c;
    logic             kick_ok_c;

    // One tracker per source; held clear whenever the FSM is not staying in RUN.
    for (genvar i = 0; i < int'(N_SRC); i++) begin : g_mon
        wdt_src_monitor #(
            .TIMEOUT_MS (TIMEOUT_MS)
        ) u_mon (
            .clk      (clk),
            .reset_n  (reset_n),
            .clr      (mon_clr_c),
            .seen_clr (kick_fire_c),
            .hb       (hb[i]),
            .tick     (tick_1ms),
            .mask     (src_mask[i]),
            .seen     (seen_vec[i]),
            .expire   (expire_vec[i])
        );
    end

    assign kick_ok_c = ((seen_vec & src_mask) == src_mask) && (since_q >= MIN_MS);
    assign mon_clr_c = (state_q != ST_RUN) || (state_d != ST_RUN);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        since_d     = since_q;
        kick_d      = kick_q;
        stall_d     = stall_q;
        kick_fire_c = 1'b0;

        case (state_q)
            ST_DISABLED: begin
                if (en) begin
                    state_d = ST_ARMING;
                end
            end
            ST_ARMING: begin
                if (tick_1ms) begin
                    hold_cnt_d = sat_inc(hold_cnt_q, HOLDOFF_MS);
                end
                if (hold_cnt_d >= HOLDOFF_MS) begin
                    state_d = ST_RUN;
                    stall_d = '0;
                end
            end
            ST_RUN: begin
                if (tick_1ms) begin
                    since_d = sat_inc(since_q, MIN_MS);
                end
                if (wdt_out) begin
                    state_d = ST_RECOVER;
                end else if (|expire_vec) begin
                    stall_d = stall_q | expire_vec;
                    state_d = ST_FAULT;
                end else if (kick_ok_c) begin
                    kick_fire_c = 1'b1;
                    kick_d      = ~kick_q;
                    since_d     = '0;
                end
            end
            ST_FAULT: begin
                if (wdt_out) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (!wdt_out) begin
                    state_d = ST_ARMING;
                end
            end
            default: begin
                state_d = ST_DISABLED;
            end
        endcase

        // Disable overrides everything; the kick level is left where it was.
        if (!en) begin
            state_d     = ST_DISABLED;
            stall_d     = '0;
            kick_d      = kick_q;
            kick_fire_c = 1'b0;
        end

        if (state_d != ST_ARMING) begin
            hold_cnt_d = '0;
        end
        if (state_d != ST_RUN) begin
            since_d = '0;
        end

        fault_d = (state_d == ST_FAULT) || (state_d == ST_RECOVER);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_DISABLED;
            hold_cnt_q <= '0;
            since_q    <= '0;
            kick_q     <= 1'b0;
            stall_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            since_q    <= since_d;
            kick_q     <= kick_d;
            stall_q    <= stall_d;
            fault_q    <= fault_d;
        end
    end

    assign kick  = kick_q;
    assign stall = stall_q;
    assign fault = fault_q;
    assign state = ST_W'(state_q);

endmodule

// File: tb/tb_wdt_kick_ctrl.sv
// Bench for wdt_kick_ctrl: ms-granular vector table plus cycle-exact corner sequences.
module tb_wdt_kick_ctrl;

    localparam logic [2:0] S_DIS = 3'd0;
    localparam logic [2:0] S_ARM = 3'd1;
    localparam logic [2:0] S_RUN = 3'd2;
    localparam logic [2:0] S_FLT = 3'd3;
    localparam logic [2:0] S_REC = 3'd4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick_1ms;
    logic       en;
    logic       wdt_out;
    logic [1:0] src_mask;
    logic [1:0] hb;
    logic       kick;
    logic [1:0] stall;
    logic       fault;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    // One record = one ms: tick on cycle 0, hb pulse on cycle 5, outputs checked at ms end.
    typedef struct {
        logic       en;
        logic [1:0] mask;
        logic [1:0] hb;
        logic [2:0] st;
        logic       kick;
        logic [1:0] stall;
        logic       fault;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic       kick;
        logic [1:0] stall;
        logic       fault;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   vi = 0;

    wdt_kick_ctrl #(
        .N_SRC      (2),
        .HOLDOFF_MS (16'd5),
        .MIN_MS     (16'd3),
        .TIMEOUT_MS (16'd8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick_1ms (tick_1ms),
        .en       (en),
        .src_mask (src_mask),
        .hb       (hb),
        .wdt_out  (wdt_out),
        .kick     (kick),
        .stall    (stall),
        .fault    (fault),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".state"}, int'(state), int'(e.st));
        chk({tag, ".kick"},  int'(kick),  int'(e.kick));
        chk({tag, ".stall"}, int'(stall), int'(e.stall));
        chk({tag, ".fault"}, int'(fault), int'(e.fault));
    endtask

    task automatic cyc(input logic t, input logic [1:0] h);
        tick_1ms = t;
        hb       = h;
        @(posedge clk);
        #1;
    endtask

    task automatic run_ms(input logic [1:0] h);
        cyc(1'b1, 2'b00);
        repeat (4) cyc(1'b0, 2'b00);
        cyc(1'b0, h);
        repeat (4) cyc(1'b0, 2'b00);
    endtask

    task automatic add(input logic e, input logic [1:0] m, input logic [1:0] h,
                       input logic [2:0] st, input logic k, input logic [1:0] s, input logic f);
        vec_t v;
        v.en = e; v.mask = m; v.hb = h;
        v.st = st; v.kick = k; v.stall = s; v.fault = f;
        tbl.push_back(v);
    endtask

    task automatic run_table(input int n, input string tag);
        vec_t v;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (vi >= tbl.size()) begin
                failures++;
                $display("FAIL %s: vector table exhausted at index %0d", tag, vi);
                return;
            end
            v = tbl[vi];
            vi++;
            en       = v.en;
            src_mask = v.mask;
            e.st = v.st; e.kick = v.kick; e.stall = v.stall; e.fault = v.fault;
            sb.push_back(e);
            run_ms(v.hb);
            e = sb.pop_front();
            chk_out($sformatf("%s[%0d]", tag, i), e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        // normal service, both sources every 2 ms
        add(1, 2'b11, 2'b11, S_RUN, 0, 2'b00, 0);
        add(1, 2'b11, 2'b00, S_RUN, 0, 2'b00, 0);
        add(1, 2'b11, 2'b11, S_RUN, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, S_RUN, 1, 2'b00, 0);
        add(1, 2'b11, 2'b11, S_RUN, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, S_RUN, 0, 2'b00, 0);
        add(1, 2'b11, 2'b11, S_RUN, 0, 2'b00, 0);
        add(1, 2'b11, 2'b00, S_RUN, 0, 2'b00, 0);
        add(1, 2'b11, 2'b11, S_RUN, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, S_RUN, 1, 2'b00, 0);
        add(1, 2'b11, 2'b11, S_RUN, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, S_RUN, 0, 2'b00, 0);
        // only hb[0] before the latency sequence
        add(1, 2'b11, 2'b01, S_RUN, 0, 2'b00, 0);
        add(1, 2'b11, 2'b00, S_RUN, 0, 2'b00, 0);
        // hb[1] silent: ticks 1..7 of silence
        for (int i = 0; i < 7; i++) add(1, 2'b11, 2'b01, S_RUN, 1, 2'b00, 0);
        // re-arming after recovery, stall held until RUN
        for (int i = 0; i < 4; i++) add(1, 2'b01, 2'b00, S_ARM, 1, 2'b10, 0);
        add(1, 2'b01, 2'b00, S_RUN, 1, 2'b00, 0);
        // mask 01, hb[0] alone
        add(1, 2'b01, 2'b01, S_RUN, 1, 2'b00, 0);
        add(1, 2'b01, 2'b01, S_RUN, 1, 2'b00, 0);
        add(1, 2'b01, 2'b01, S_RUN, 0, 2'b00, 0);
        add(1, 2'b01, 2'b01, S_RUN, 0, 2'b00, 0);
        add(1, 2'b01, 2'b01, S_RUN, 0, 2'b00, 0);
        add(1, 2'b01, 2'b01, S_RUN, 1, 2'b00, 0);
        add(1, 2'b01, 2'b01, S_RUN, 1, 2'b00, 0);
        add(1, 2'b01, 2'b01, S_RUN, 1, 2'b00, 0);
        add(1, 2'b01, 2'b01, S_RUN, 0, 2'b00, 0);
        // mask 00, free-running
        add(1, 2'b00, 2'b00, S_RUN, 0, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 0, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 1, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 1, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 1, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 0, 2'b00, 0);
        // mask 01, one hb then silence up to age 7
        add(1, 2'b01, 2'b01, S_RUN, 0, 2'b00, 0);
        add(1, 2'b01, 2'b00, S_RUN, 0, 2'b00, 0);
        for (int i = 0; i < 6; i++) add(1, 2'b01, 2'b00, S_RUN, 1, 2'b00, 0);
        // after hb+tick collision: 7 more quiet ms
        for (int i = 0; i < 7; i++) add(1, 2'b01, 2'b00, S_RUN, 0, 2'b00, 0);
        // re-arm after disable, mask 00
        for (int i = 0; i < 4; i++) add(1, 2'b00, 2'b00, S_ARM, 0, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 0, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 0, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 0, 2'b00, 0);
        add(1, 2'b00, 2'b00, S_RUN, 1, 2'b00, 0);
        // re-arm after mid-RUN disable
        for (int i = 0; i < 4; i++) add(1, 2'b11, 2'b00, S_ARM, 1, 2'b00, 0);
        add(1, 2'b11, 2'b00, S_RUN, 1, 2'b00, 0);

        // reset and arming
        reset_n = 1'b0; en = 1'b1; src_mask = 2'b11; wdt_out = 1'b0;
        tick_1ms = 1'b0; hb = 2'b00;
        repeat (3) cyc(1'b0, 2'b00);
        chk("rst.state", int'(state), int'(S_DIS));
        chk("rst.kick", int'(kick), 0);
        chk("rst.stall", int'(stall), 0);
        chk("rst.fault", int'(fault), 0);
        reset_n = 1'b1;
        cyc(1'b0, 2'b00);
        chk("arm.entry", int'(state), int'(S_ARM));
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 2'b00);
            chk($sformatf("arm.tick%0d", k), int'(state), int'((k < 5) ? S_ARM : S_RUN));
            chk($sformatf("arm.kick%0d", k), int'(kick), 0);
            chk($sformatf("arm.stall%0d", k), int'(stall), 0);
            for (int j = 1; j <= 9; j++) cyc(1'b0, (j == 5 && k < 5) ? 2'b11 : 2'b00);
        end

        run_table(12, "service");
        run_table(2, "prelat");

        // service latency: last required hb -> kick two edges later
        cyc(1'b1, 2'b00);
        chk("lat.tick", int'(kick), 0);
        repeat (4) cyc(1'b0, 2'b00);
        cyc(1'b0, 2'b10);
        chk("lat.hb_edge", int'(kick), 0);
        cyc(1'b0, 2'b00);
        chk("lat.hb_plus1", int'(kick), 1);
        repeat (3) cyc(1'b0, 2'b00);

        run_table(7, "silent");

        // 8th silent tick declares the fault on its own edge
        cyc(1'b1, 2'b01);
        chk("tmo.state", int'(state), int'(S_FLT));
        chk("tmo.stall", int'(stall), 2);
        chk("tmo.fault", int'(fault), 1);
        chk("tmo.kick", int'(kick), 1);
        repeat (9) cyc(1'b0, 2'b00);
        chk("flt.hold", int'(state), int'(S_FLT));

        // recovery via a 20-cycle wdt_out pulse
        wdt_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 2'b00);
            chk($sformatf("rec.state%0d", i), int'(state), int'(S_REC));
        end
        chk("rec.fault", int'(fault), 1);
        chk("rec.stall", int'(stall), 2);
        chk("rec.kick", int'(kick), 1);
        wdt_out = 1'b0;
        cyc(1'b0, 2'b00);
        chk("rec.fall", int'(state), int'(S_ARM));
        chk("rec.fall_fault", int'(fault), 0);
        chk("rec.fall_stall", int'(stall), 2);

        run_table(5, "rearm");
        run_table(9, "mask01");
        run_table(6, "mask00");
        run_table(8, "age7");

        // hb and tick together while age is 7: no fault, age restarts
        cyc(1'b1, 2'b01);
        chk("coll.state", int'(state), int'(S_RUN));
        chk("coll.fault", int'(fault), 0);
        chk("coll.stall", int'(stall), 0);
        cyc(1'b0, 2'b00);
        chk("coll.kick", int'(kick), 0);
        repeat (8) cyc(1'b0, 2'b00);

        run_table(7, "quiet");

        cyc(1'b1, 2'b00);
        chk("coll.tmo_state", int'(state), int'(S_FLT));
        chk("coll.tmo_stall", int'(stall), 1);

        // disable from FAULT clears stall
        en = 1'b0;
        cyc(1'b0, 2'b00);
        chk("dis.state", int'(state), int'(S_DIS));
        chk("dis.stall", int'(stall), 0);
        chk("dis.fault", int'(fault), 0);
        en = 1'b1;
        cyc(1'b0, 2'b00);
        chk("dis.rearm", int'(state), int'(S_ARM));

        run_table(8, "freerun");

        // disable mid-RUN: DISABLED next edge, kick level kept
        cyc(1'b1, 2'b00);
        cyc(1'b0, 2'b00);
        chk("mid.run", int'(state), int'(S_RUN));
        en = 1'b0;
        cyc(1'b0, 2'b00);
        chk("mid.state", int'(state), int'(S_DIS));
        chk("mid.kick", int'(kick), 1);
        run_ms(2'b11);
        chk("mid.hold_state", int'(state), int'(S_DIS));
        chk("mid.hold_kick", int'(kick), 1);
        en = 1'b1;
        src_mask = 2'b11;
        cyc(1'b0, 2'b00);
        chk("mid.rearm", int'(state), int'(S_ARM));

        run_table(5, "rearm2");

        // premature WDT reset in RUN: RECOVER without stall
        wdt_out = 1'b1;
        cyc(1'b0, 2'b00);
        chk("ext.state", int'(state), int'(S_REC));
        chk("ext.stall", int'(stall), 0);
        chk("ext.fault", int'(fault), 1);
        chk("ext.kick", int'(kick), 1);
        repeat (2) cyc(1'b0, 2'b00);
        wdt_out = 1'b0;
        cyc(1'b0, 2'b00);
        chk("ext.fall", int'(state), int'(S_ARM));
        chk("ext.fall_fault", int'(fault), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wdt_kick_ctrl.md
# wdt_kick_ctrl

- Sits between the application tasks (frequency counter, display, UART, …) and the `WDT` block, and drives the WDT's kick input.
- Each supervised task reports liveness with a heartbeat pulse. The WDT is serviced only when every enabled task has checked in and a minimum service interval has elapsed.
- If any enabled task goes silent past a timeout, kicking stops and the WDT is deliberately allowed to fire.
- All timing is in milliseconds, counted from a 1 kHz tick strobe in the `clk` domain.

## Interface

**Parameters**
- `N_SRC`, 4: number of heartbeat sources.
- `HOLDOFF_MS`, 16'd100: ms to wait after reset, enable or recovery before supervision starts.
- `MIN_MS`, 16'd10: minimum ms between two kicks.
- `TIMEOUT_MS`, 16'd40: ms of silence from an enabled source that declares a fault; must be > `MIN_MS`.

**Ports**
- `clk` in 1: system clock. One clock only.
- `reset_n` in 1: synchronous, active-low reset.
- `tick_1ms` in 1: single-cycle strobe, once per ms, synchronous to `clk`.
- `en` in 1: supervision enable.
- `src_mask` in N_SRC: 1 = source is supervised.
- `hb` in N_SRC: heartbeat pulses, one or more cycles high.
- `wdt_out` in 1: reset output of `WDT`, active-high.
- `kick` out 1: to the WDT kick input. Level toggles once per service.
- `stall` out N_SRC: sticky, marks sources that timed out.
- `fault` out 1: high in FAULT and RECOVER states.
- `state` out 3: current FSM state, for debug.

## Operation

**FSM states:** DISABLED, ARMING, RUN, FAULT, RECOVER.

**Reset values**
- State DISABLED; `kick`=0, `stall`=0, `fault`=0.
- All counters and `seen` bits cleared.

**Transitions out of DISABLED**
- `en`=1 → ARMING.
- `en`=0 in any state → DISABLED on the next edge. `kick` holds its level; counters, `seen` and `stall` are cleared.

**ARMING**
- Counts ticks in `hold_cnt`.
- When `hold_cnt` reaches `HOLDOFF_MS`, go to RUN and clear all ages and `seen`.
- Heartbeats are ignored.

**RUN: per-source tracking**
- `seen[i]` is set on `hb[i]`.
- `age[i]` is cleared on `hb[i]`; otherwise it increments on each tick, saturating at `TIMEOUT_MS`.
- `since` counts ticks since the last kick, saturating at `MIN_MS`.

**RUN: service (kick)**
- Condition: `(seen & src_mask) == src_mask` and `since >= MIN_MS`.
- Action: toggle `kick`, clear `seen` and `since`.
- With `src_mask`=0, kicks occur every `MIN_MS` ticks (free-running).

**RUN: fault detection**
- Condition: `tick_1ms`=1 and, for some i, `src_mask[i]`=1, `hb[i]`=0 and `age[i]` == `TIMEOUT_MS`-1.
- Action: set `stall[i]` for every such i, then go to FAULT.
- Fault takes priority over a kick in the same cycle: no toggle.

**FAULT**
- `kick` is frozen, `fault`=1, and `stall` is held.
- `wdt_out`=1 → RECOVER.

**RECOVER**
- Wait while `wdt_out`=1.
- On `wdt_out` falling to 0 → ARMING. `stall` stays latched until the next ARMING→RUN transition; it is then cleared.

**Other rules**
- `hb` and `tick_1ms` in the same cycle: the heartbeat wins, `age` goes to 0.
- `wdt_out`=1 while in RUN (an external or premature WDT reset): go to RECOVER without setting `stall`.
- `src_mask` is sampled every cycle. Clearing a bit removes that source from both the service and timeout conditions immediately.

## Timing

- `hb[i]` high at edge t → `seen[i]`=1 after t → `kick` toggles after edge t+1. Worst-case service latency is 2 cycles from the last required heartbeat.
- `kick` toggles at most once per `MIN_MS` ticks.
- Fault is declared on the edge of the `TIMEOUT_MS`-th tick without a heartbeat; `stall` and `state` update on that same edge.
- ARMING→RUN occurs on the edge of the `HOLDOFF_MS`-th tick after entering ARMING.
- All counters are 16 bits unsigned and saturate. No wrap-around is permitted.
- All outputs are registered.

## Structure

- **Package `wdt_pkg`:** state encoding constants `ST_DISABLED`=0, `ST_ARMING`=1, `ST_RUN`=2, `ST_FAULT`=3, `ST_RECOVER`=4, and the 16-bit ms counter width constant.
- **Sub-module `wdt_src_monitor`:** instantiated `N_SRC` times. It holds one `age` counter and one `seen` bit, with inputs `clr`, `hb`, `tick` and `mask`, and outputs `seen` and `expire`.
- **Top level:** FSM, `hold_cnt`, `since`, kick toggle register, `stall` latch.

## Test plan

Common setup: `N_SRC`=2, `HOLDOFF_MS`=5, `MIN_MS`=3, `TIMEOUT_MS`=8, one tick every 10 clk.

1. **Reset and arming.** Release reset with `en`=1 and both mask bits set → state ARMING, RUN after exactly 5 ticks; `kick`=0, `stall`=0 throughout.
2. **Normal service.** Both sources pulse every 2 ms → `kick` toggles every 3 ms; each toggle occurs 2 cycles after the later heartbeat once `since`≥3; `fault` stays 0.
3. **Source timeout.** `hb[1]` stops while `hb[0]` continues → no further toggles; on the 8th silent tick `stall`=2'b10 and state FAULT.
4. **Recovery.** In FAULT, pulse `wdt_out` high for 20 cycles → RECOVER while high, ARMING on its fall; `stall` cleared after 5 ticks when RUN is entered.
5. **Masking.** Set `src_mask`=2'b01 with `hb[1]` silent → kicks continue every 3 ms driven by `hb[0]` alone; `src_mask`=0 → kick every 3 ticks with no heartbeats.
6. **Simultaneous events.** `hb[0]` and a tick on the cycle where `age[0]`=7 → no fault, `age[0]`=0. Deassert `en` mid-RUN → DISABLED next edge, `kick` level held.
